mem_port_arbiter: RTL

//  Shares the single 32-bit memory port between instruction fetch (I) and load/store (D).

---
 rtl/mem_port_arbiter_if.sv | 35 +++
 rtl/mem_port_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Request, completion and memory-port signals shared between the fetch/load-store
// requesters, the memory and mem_port_arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_W = 32
);
    logic              i_req;
    logic [DATA_W-1:0] i_addr;
    logic              i_done;
    logic              d_req;
    logic              d_we;
    logic [DATA_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] rdata;
    logic              sel;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        output i_done, d_done, rdata, sel, mem_valid, mem_addr, mem_we, mem_wdata, err
    );

    // Requester / memory side
    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
        input  i_done, d_done, rdata, sel, mem_valid, mem_addr, mem_we, mem_wdata, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store: data has priority,
// a streak cap keeps fetch from starving, and a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned STREAK_W = $clog2(STREAK_MAX + 1);
    localparam int unsigned WDOG_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(STREAK_MAX);
    localparam logic [WDOG_W-1:0]   WDOG_LAST  = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                sel_q, sel_d;
    logic                valid_q;

    logic busy, finish, abort;
    logic ireq_e, dreq_e, force_i;

    assign busy    = (state_q != IDLE);
    assign finish  = busy && bus.mem_ready;
    assign abort   = busy && !bus.mem_ready && (wdog_q == WDOG_LAST);
    // The requester completing this cycle still holds req; it must not be re-granted.
    assign ireq_e  = bus.i_req && (state_q != BUSY_I);
    assign dreq_e  = bus.d_req && (state_q != BUSY_D);
    assign force_i = ireq_e && (streak_q == STREAK_CAP);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            wdog_q   <= '0;
            sel_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            wdog_q   <= wdog_d;
            sel_q    <= sel_d;
            valid_q  <= (state_d != IDLE);
        end
    end

    // Arbitration on idle or completion; watchdog count otherwise
    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        wdog_d   = wdog_q;
        sel_d    = sel_q;
        if (abort) begin
            state_d = IDLE;
        end else if (!busy || finish) begin
            if (dreq_e && !force_i) begin
                state_d = BUSY_D;
                sel_d   = 1'b1;
                wdog_d  = '0;
                if (!bus.i_req) begin
                    streak_d = '0;
                end else if (streak_q != STREAK_CAP) begin
                    streak_d = streak_q + STREAK_W'(1);
                end
            end else if (ireq_e) begin
                state_d  = BUSY_I;
                sel_d    = 1'b0;
                wdog_d   = '0;
                streak_d = '0;
            end else begin
                state_d = IDLE;
            end
        end else begin
            wdog_d = wdog_q + WDOG_W'(1);
        end
    end

    // Completion pulses are combinational so the requester sees rdata in the same cycle.
    assign bus.i_done    = (state_q == BUSY_I) && (finish || abort);
    assign bus.d_done    = (state_q == BUSY_D) && (finish || abort);
    assign bus.err       = abort;
    assign bus.rdata     = DATA_W'(bus.mem_rdata);
    assign bus.sel       = sel_q;
    assign bus.mem_valid = valid_q;
    assign bus.mem_addr  = DATA_W'(sel_q ? bus.d_addr : bus.i_addr);
    assign bus.mem_we    = sel_q & bus.d_we & valid_q;
    assign bus.mem_wdata = DATA_W'(bus.d_wdata);
endmodule
